// File: rtl/math_equation_arbiter.sv
// Round-robin front end for one shared fixed-latency math_equation datapath.
// Tags follow each operation through the pipe; credits keep the result FIFO from overflowing.
module math_equation_arbiter #(
  parameter int WIDTH      = 16,
  parameter int NUM_REQ    = 4,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]        req_a,
  input  logic [NUM_REQ*WIDTH-1:0]        req_b,
  input  logic [NUM_REQ*WIDTH-1:0]        req_c,
  input  logic [NUM_REQ*WIDTH-1:0]        req_d,
  output logic                            eq_valid_o,
  output logic [WIDTH-1:0]                eq_a,
  output logic [WIDTH-1:0]                eq_b,
  output logic [WIDTH-1:0]                eq_c,
  output logic [WIDTH-1:0]                eq_d,
  input  logic                            eq_valid_i,
  input  logic [2*WIDTH+1:0]              eq_q,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [2*WIDTH+1:0]              res_q,
  output logic [ID_W-1:0]                 res_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] inflight,
  output logic                            err
);

  localparam int QW = 2*WIDTH + 2;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]     DEPTH_X  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH-1);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ-1);

  if (NUM_REQ < 2 || LAT < 1 || FIFO_DEPTH < 1) begin : g_bad_params
    $error("math_equation_arbiter: unsupported parameter set");
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + 1'b1;
  endfunction

  logic [ID_W-1:0]    ptr_r, gid_s, idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               found_s, credit_s, accept_s, ret_s, push_s, pop_s, full_s;
  logic [CW-1:0]      count_r, count_next_s;
  logic [ID_W-1:0]    tag_mem_r [FIFO_DEPTH];
  logic [PW-1:0]      tag_wr_r, tag_rd_r;
  logic [QW-1:0]      q_mem_r [FIFO_DEPTH];
  logic [ID_W-1:0]    id_mem_r [FIFO_DEPTH];
  logic [PW-1:0]      wr_r, rd_r;

  // Round-robin search from ptr+1; the grant is withheld while no credit remains.
  always_comb begin
    grant_s = '0;
    gid_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s        = 1'b1;
        grant_s[idx_s] = 1'b1;
        gid_s          = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    credit_s  = ({1'b0, count_r} + {1'b0, inflight}) < DEPTH_X;
    req_ready = (credit_s && !rst) ? grant_s : '0;
  end

  assign accept_s = |(req_valid & req_ready);
  assign full_s   = (count_r == DEPTH_C);
  assign ret_s    = eq_valid_i && (inflight != '0);
  assign push_s   = ret_s && !full_s;
  assign pop_s    = res_valid && res_ready;
  assign res_q    = q_mem_r[rd_r];
  assign res_id   = id_mem_r[rd_r];

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
  end

  // Arbitration pointer and operand issue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= LAST_ID;
      eq_valid_o <= 1'b0;
      eq_a       <= '0;
      eq_b       <= '0;
      eq_c       <= '0;
      eq_d       <= '0;
    end else begin
      eq_valid_o <= accept_s;
      if (accept_s) begin
        ptr_r <= gid_s;
        eq_a  <= req_a[int'(gid_s)*WIDTH +: WIDTH];
        eq_b  <= req_b[int'(gid_s)*WIDTH +: WIDTH];
        eq_c  <= req_c[int'(gid_s)*WIDTH +: WIDTH];
        eq_d  <= req_d[int'(gid_s)*WIDTH +: WIDTH];
      end
    end
  end

  // In-flight count, tag/result queue pointers, occupancy and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= '0;
      tag_wr_r  <= '0;
      tag_rd_r  <= '0;
      wr_r      <= '0;
      rd_r      <= '0;
      count_r   <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case ({accept_s, ret_s})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (accept_s) tag_wr_r <= next_ptr(tag_wr_r);
      if (ret_s)    tag_rd_r <= next_ptr(tag_rd_r);
      if (push_s)   wr_r     <= next_ptr(wr_r);
      if (pop_s)    rd_r     <= next_ptr(rd_r);
      count_r   <= count_next_s;
      res_valid <= (count_next_s != '0);
      if (eq_valid_i && ((inflight == '0) || full_s)) err <= 1'b1;
    end
  end

  // Storage arrays carry no reset; occupancy state alone says what is live.
  always_ff @(posedge clk) begin
    if (accept_s) tag_mem_r[tag_wr_r] <= gid_s;
    if (push_s) begin
      q_mem_r[wr_r]  <= eq_q;
      id_mem_r[wr_r] <= tag_mem_r[tag_rd_r];
    end
  end

endmodule

// File: tb/tb_math_equation_arbiter.sv
// Bench for math_equation_arbiter: directed vectors, corner sequences and random traffic
// checked against a cycle-level transaction model of arbitration, credits and results.
module tb_math_equation_arbiter;

  localparam int WIDTH = 16, NUM_REQ = 4, LAT = 3, FIFO_DEPTH = 4, ID_W = 2;
  localparam int QW = 2*WIDTH + 2, CW = $clog2(FIFO_DEPTH+1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b, req_c, req_d;
  logic eq_valid_o, eq_valid_i, res_valid, res_ready, err, inj;
  logic [WIDTH-1:0] eq_a, eq_b, eq_c, eq_d;
  logic [QW-1:0] eq_q, res_q;
  logic [ID_W-1:0] res_id;
  logic [CW-1:0] inflight;

  always #5 clk = ~clk;

  math_equation_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LAT(LAT),
                          .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .eq_valid_o(eq_valid_o), .eq_a(eq_a), .eq_b(eq_b), .eq_c(eq_c), .eq_d(eq_d),
    .eq_valid_i(eq_valid_i), .eq_q(eq_q), .res_valid(res_valid), .res_ready(res_ready),
    .res_q(res_q), .res_id(res_id), .inflight(inflight), .err(err));

  function automatic logic [QW-1:0] ref_q(input logic [15:0] a, b, c, d);
    longint r;
    r = (64'sd1 + 64'sd3 * longint'($signed(c))) * (longint'($signed(a)) - longint'($signed(b)))
        - 64'sd4 * longint'($signed(d));
    r = r >>> 1;
    return r[QW-1:0];
  endfunction

  // Datapath stand-in: fixed LAT pipeline sharing rst.
  logic [LAT-1:0] dp_v;
  logic [QW-1:0]  dp_q [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) dp_v <= '0;
    else begin
      dp_v    <= {dp_v[LAT-2:0], eq_valid_o};
      dp_q[0] <= ref_q(eq_a, eq_b, eq_c, eq_d);
      for (int k = 1; k < LAT; k++) dp_q[k] <= dp_q[k-1];
    end
  end
  assign eq_valid_i = dp_v[LAT-1] | inj;
  assign eq_q       = dp_q[LAT-1];

  typedef struct {int id; logic [QW-1:0] q;} exp_t;
  typedef struct {int id; logic [15:0] a, b, c, d; logic [QW-1:0] q;} vec_t;

  int n_pass = 0, n_total = 0;
  int m_ptr, m_acc, m_cons, m_ret, m_cyc = 0;
  bit m_prev_acc, m_err;
  exp_t expq[$];
  int rt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_ptr = NUM_REQ-1; m_acc = 0; m_cons = 0; m_ret = 0;
    m_prev_acc = 1'b0; m_err = 1'b0;
    expq.delete(); rt.delete();
  endtask

  task automatic set_ops(input int id, input logic [15:0] a, b, c, d);
    req_a[id*WIDTH +: WIDTH] = a; req_b[id*WIDTH +: WIDTH] = b;
    req_c[id*WIDTH +: WIDTH] = c; req_d[id*WIDTH +: WIDTH] = d;
  endtask

  // Called at a negedge: check this cycle against the model, advance it, move to posedge+1.
  task automatic step();
    logic [NUM_REQ-1:0] er;
    int gid, idx;
    bit acc, pop;
    er = '0; gid = 0;
    if ((m_acc - m_cons) < FIFO_DEPTH)
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (er == '0 && req_valid[idx]) begin er[idx] = 1'b1; gid = idx; end
      end
    chk("req_ready", req_ready, er);
    chk("eq_valid_o", eq_valid_o, m_prev_acc);
    chk("inflight", inflight, m_acc - m_ret);
    chk("res_valid", res_valid, m_ret > m_cons);
    chk("err", err, m_err);
    pop = (m_ret > m_cons) && res_ready;
    if (pop) begin
      if (expq.size() > 0) begin
        chk("res_q", res_q, expq[0].q);
        chk("res_id", res_id, expq[0].id);
        expq.delete(0);
      end
      m_cons++;
    end
    if (inj && m_acc == m_ret) m_err = 1'b1;
    acc = (req_valid & er) != '0;
    if (acc) begin
      expq.push_back('{gid, ref_q(req_a[gid*WIDTH +: WIDTH], req_b[gid*WIDTH +: WIDTH],
                                  req_c[gid*WIDTH +: WIDTH], req_d[gid*WIDTH +: WIDTH])});
      rt.push_back(m_cyc + 1 + LAT);
      m_ptr = gid; m_acc++;
    end
    if (rt.size() > 0 && rt[0] == m_cyc) begin rt.delete(0); m_ret++; end
    m_prev_acc = acc; m_cyc++;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(negedge clk); step(); end
  endtask

  task automatic run_single(input vec_t v);
    logic [NUM_REQ-1:0] oh;
    bit found;
    found = 1'b0; oh = '0; oh[v.id] = 1'b1;
    req_valid = '0; req_valid[v.id] = 1'b1;
    set_ops(v.id, v.a, v.b, v.c, v.d);
    @(negedge clk); chk("single_ready", req_ready, oh); step();
    req_valid = '0;
    for (int k = 1; k <= 12 && !found; k++) begin
      @(negedge clk);
      if (k == 1) chk("single_issue", eq_valid_o, 1'b1);
      if (res_valid) begin
        found = 1'b1;
        chk("single_latency", k, LAT + 2);
        chk("single_q", res_q, v.q);
        chk("single_id", res_id, v.id);
      end
      step();
    end
    if (!found) begin n_total++; $display("FAIL single_timeout: no res_valid within 12 cycles"); end
  endtask

  vec_t vec [5];
  int n_acc;
  bit done;

  initial begin
    vec[0] = '{2, 16'd10, 16'd4, 16'd2, 16'd1, 34'd19};
    vec[1] = '{0, 16'd0, 16'd5, 16'hFFFF, 16'd2, 34'd1};
    vec[2] = '{0, 16'd0, 16'd1, 16'd0, 16'd1, -34'sd3};
    vec[3] = '{1, 16'd100, 16'hFF9C, 16'd3, 16'd50, 34'd900};
    vec[4] = '{3, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, -34'sd3221045249};

    req_valid = '0; res_ready = 1'b1; inj = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_eq_valid", eq_valid_o, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_inflight", inflight, 3'd0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    model_reset();

    for (int i = 0; i < 5; i++) run_single(vec[i]);

    // All requesters held high: eight accepts must rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NUM_REQ; i++)
      set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    req_valid = '1; n_acc = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rr_order", req_ready, 4'b0001 << (n_acc % NUM_REQ));
        n_acc++;
      end
      step();
      if (n_acc == 8) begin req_valid = '0; done = 1'b1; end
    end
    if (!done) begin n_total++; $display("FAIL rr_timeout: %0d accepts, need 8", n_acc); end
    req_valid = '0;
    cycles(12);

    // Backpressure: exactly FIFO_DEPTH accepts, then one slot per released pop.
    res_ready = 1'b0; req_valid = '1; n_acc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (req_ready != '0) n_acc++;
      step();
    end
    chk("bp_accepts", n_acc, FIFO_DEPTH);
    res_ready = 1'b1;
    @(negedge clk); chk("bp_pop_cycle_ready", req_ready, 4'b0000); step();
    res_ready = 1'b0;
    @(negedge clk); chk("bp_next_cycle_accept", req_ready != '0, 1'b1); step();
    @(negedge clk); chk("bp_full_again", req_ready, 4'b0000); step();
    req_valid = '0; res_ready = 1'b1;
    cycles(15);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req_valid = NUM_REQ'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++)
        set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk); step();
    end
    req_valid = '0; res_ready = 1'b1;
    cycles(20);
    chk("drain_inflight", inflight, 3'd0);
    chk("drain_res_valid", res_valid, 1'b0);

    // Reset with work both in flight and queued.
    res_ready = 1'b0; req_valid = '1;
    cycles(6);
    chk("pre_rst_inflight", inflight, 3'd2);
    chk("pre_rst_res_valid", res_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 4'b0000);
    chk("mid_rst_eq_valid", eq_valid_o, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_inflight", inflight, 3'd0);
    chk("mid_rst_err", err, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    req_valid = '0; res_ready = 1'b1;
    model_reset();
    run_single('{1, 16'd10, 16'd4, 16'd2, 16'd1, 34'd19});

    // Spurious datapath valid with nothing in flight.
    inj = 1'b1;
    @(negedge clk); step();
    inj = 1'b0;
    cycles(4);
    chk("err_sticky", err, 1'b1);
    chk("err_no_result", res_valid, 1'b0);
    rst = 1'b1;
    #1 chk("err_cleared", err, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    model_reset();
    cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
